sfu_seq: RTL and testbench

SFU_SEQ -- requirements
Module: sfu_seq

---
 rtl/sfu_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_sfu_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_seq.sv
// ---------------------------------------------------------------------------
// sfu_seq -- special-function sequencer for LayerNorm, RoPE and (optionally)
// RMSNorm over a DIM-element vector of DW-bit two's-complement values.
// All multiplications are done by an external vector processing engine (VPE).
// This block only sequences the work and performs the adds, subtracts and
// negates. Those operations wrap modulo 2^DW.
//
// Configuration macro: SFU_RMSNORM_EN
//   defined   -> op 2'b10 runs RMSNorm (LayerNorm with the mean step skipped)
//   undefined -> op 2'b10 is illegal and the RMSNorm load path is not built
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   job handshake; in_ready is high only when idle
//   op                    00 LayerNorm, 01 RoPE, 10 RMSNorm, 11 illegal
//   data_i                input vector x
//   mean_i/rstd_i/beta_i  LayerNorm scalars
//   sin_i / cos_i         RoPE coefficients, one per element pair
//   out_valid/out_ready   result handshake; data_o holds y
//   err_o                 one-cycle pulse after an illegal op is accepted
//   busy_o                high whenever the sequencer is not idle
//   vpe_req / vpe_ack     VPE request, held until acknowledged
//   vpe_mode              0 vector*scalar, 1 vector*vector
//   vpe_vec1/vpe_vec2/vpe_sca  VPE operands
//   vpe_res               VPE result, valid in the vpe_ack cycle
//
// DIM must be even and at least 2.
// ---------------------------------------------------------------------------
module sfu_seq #(
  parameter int DIM = 128,
  parameter int DW  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [DIM-1:0][DW-1:0]   data_i,
  input  logic [DW-1:0]            mean_i,
  input  logic [DW-1:0]            rstd_i,
  input  logic [DW-1:0]            beta_i,
  input  logic [DIM/2-1:0][DW-1:0] sin_i,
  input  logic [DIM/2-1:0][DW-1:0] cos_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM-1:0][DW-1:0]   data_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic                     vpe_req,
  input  logic                     vpe_ack,
  output logic                     vpe_mode,
  output logic [DIM-1:0][DW-1:0]   vpe_vec1,
  output logic [DIM-1:0][DW-1:0]   vpe_vec2,
  output logic [DW-1:0]            vpe_sca,
  input  logic [DIM-1:0][DW-1:0]   vpe_res
);

  typedef enum logic [2:0] {
    S_IDLE, S_LN_SUB, S_LN_MUL, S_LN_ADD,
    S_RP_COS, S_RP_SIN, S_RP_SUM, S_OUT
  } stateT;

  stateT r_state;
  stateT w_nextState;

  // Job operands captured on accept so later input changes have no effect.
  logic [DIM-1:0][DW-1:0]   r_x;
  logic [DW-1:0]            r_mean;
  logic [DW-1:0]            r_rstd;
  logic [DW-1:0]            r_beta;
  logic [DIM/2-1:0][DW-1:0] r_sin;
  logic [DIM/2-1:0][DW-1:0] r_cos;

  // r_acc holds diff (LN/RMS) or p (RoPE); r_prod holds prod (LN/RMS) or q.
  logic [DIM-1:0][DW-1:0]   r_acc;
  logic [DIM-1:0][DW-1:0]   r_prod;
  logic [DIM-1:0][DW-1:0]   r_y;
  logic                     r_err;

  logic                     w_accept;
  logic                     w_opLegal;
  logic [DIM-1:0][DW-1:0]   w_xr;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Decide which op codes start a job in this build.
  always_comb begin
    w_opLegal = 1'b0;
    case (op)
      2'b00:   w_opLegal = 1'b1;
      2'b01:   w_opLegal = 1'b1;
`ifdef SFU_RMSNORM_EN
      2'b10:   w_opLegal = 1'b1;
`endif
      default: w_opLegal = 1'b0;
    endcase
  end

  // Rotated vector for the sine half of RoPE: each pair (a, b) becomes (-b, a).
  always_comb begin
    w_xr = '0;
    for (int k = 0; k < DIM/2; k++) begin
      w_xr[2*k]   = -r_x[2*k+1];
      w_xr[2*k+1] = r_x[2*k];
    end
  end

  // State register; reset drops straight back to idle, discarding any job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the handshake/status outputs decoded from the state.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    vpe_req     = 1'b0;
    busy_o      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (op)
            2'b00:   w_nextState = S_LN_SUB;
            2'b01:   w_nextState = S_RP_COS;
`ifdef SFU_RMSNORM_EN
            2'b10:   w_nextState = S_LN_MUL;
`endif
            default: w_nextState = S_IDLE;
          endcase
        end
      end
      S_LN_SUB: w_nextState = S_LN_MUL;
      S_LN_MUL: begin
        vpe_req = 1'b1;
        if (vpe_ack) w_nextState = S_LN_ADD;
      end
      S_LN_ADD: w_nextState = S_OUT;
      S_RP_COS: begin
        vpe_req = 1'b1;
        if (vpe_ack) w_nextState = S_RP_SIN;
      end
      S_RP_SIN: begin
        vpe_req = 1'b1;
        if (vpe_ack) w_nextState = S_RP_SUM;
      end
      S_RP_SUM: w_nextState = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // VPE operand mux. Operands come only from job registers, so they stay
  // stable for as long as a request waits for its acknowledge.
  always_comb begin
    vpe_mode = 1'b0;
    vpe_vec1 = '0;
    vpe_vec2 = '0;
    vpe_sca  = '0;
    case (r_state)
      S_LN_MUL: begin
        vpe_vec1 = r_acc;
        vpe_sca  = r_rstd;
      end
      S_RP_COS: begin
        vpe_mode = 1'b1;
        vpe_vec1 = r_x;
        for (int k = 0; k < DIM/2; k++) begin
          vpe_vec2[2*k]   = r_cos[k];
          vpe_vec2[2*k+1] = r_cos[k];
        end
      end
      S_RP_SIN: begin
        vpe_mode = 1'b1;
        vpe_vec1 = w_xr;
        for (int k = 0; k < DIM/2; k++) begin
          vpe_vec2[2*k]   = r_sin[k];
          vpe_vec2[2*k+1] = r_sin[k];
        end
      end
      default: ;
    endcase
  end

  // Datapath: capture the job, then one register update per arithmetic step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_mean <= '0;
      r_rstd <= '0;
      r_beta <= '0;
      r_sin  <= '0;
      r_cos  <= '0;
      r_acc  <= '0;
      r_prod <= '0;
      r_y    <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept && !w_opLegal;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x    <= data_i;
            r_mean <= mean_i;
            r_rstd <= rstd_i;
            r_beta <= beta_i;
            r_sin  <= sin_i;
            r_cos  <= cos_i;
`ifdef SFU_RMSNORM_EN
            // RMSNorm has no mean step, so x goes straight in as diff.
            if (op == 2'b10) r_acc <= data_i;
`endif
          end
        end
        S_LN_SUB: begin
          for (int i = 0; i < DIM; i++) r_acc[i] <= r_x[i] - r_mean;
        end
        S_LN_MUL: begin
          if (vpe_ack) r_prod <= vpe_res;
        end
        S_LN_ADD: begin
          for (int i = 0; i < DIM; i++) r_y[i] <= r_prod[i] + r_beta;
        end
        S_RP_COS: begin
          if (vpe_ack) r_acc <= vpe_res;
        end
        S_RP_SIN: begin
          if (vpe_ack) r_prod <= vpe_res;
        end
        S_RP_SUM: begin
          for (int i = 0; i < DIM; i++) r_y[i] <= r_acc[i] + r_prod[i];
        end
        default: ;
      endcase
    end
  end

  assign data_o = r_y;
  assign err_o  = r_err;

endmodule

// File: tb/tb_sfu_seq.sv
// ---------------------------------------------------------------------------
// tb_sfu_seq -- self-checking bench for sfu_seq with DIM=4, DW=16.
// The bench plays the VPE itself (element-wise products, configurable ack
// delay) and predicts every operand and result from the job's arithmetic.
// ---------------------------------------------------------------------------
module tb_sfu_seq;

  localparam int DIM = 4;
  localparam int DW  = 16;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               op;
  logic [DIM-1:0][DW-1:0]   data_i;
  logic [DW-1:0]            mean_i;
  logic [DW-1:0]            rstd_i;
  logic [DW-1:0]            beta_i;
  logic [DIM/2-1:0][DW-1:0] sin_i;
  logic [DIM/2-1:0][DW-1:0] cos_i;
  logic                     out_valid;
  logic                     out_ready;
  logic [DIM-1:0][DW-1:0]   data_o;
  logic                     err_o;
  logic                     busy_o;
  logic                     vpe_req;
  logic                     vpe_ack;
  logic                     vpe_mode;
  logic [DIM-1:0][DW-1:0]   vpe_vec1;
  logic [DIM-1:0][DW-1:0]   vpe_vec2;
  logic [DW-1:0]            vpe_sca;
  logic [DIM-1:0][DW-1:0]   vpe_res;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Job currently being applied.
  logic [DIM-1:0][DW-1:0]   jx;
  logic [DW-1:0]            jmean;
  logic [DW-1:0]            jrstd;
  logic [DW-1:0]            jbeta;
  logic [DIM/2-1:0][DW-1:0] jsin;
  logic [DIM/2-1:0][DW-1:0] jcos;

  sfu_seq #(.DIM(DIM), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_i(data_i), .mean_i(mean_i), .rstd_i(rstd_i), .beta_i(beta_i),
    .sin_i(sin_i), .cos_i(cos_i),
    .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o),
    .err_o(err_o), .busy_o(busy_o),
    .vpe_req(vpe_req), .vpe_ack(vpe_ack), .vpe_mode(vpe_mode),
    .vpe_vec1(vpe_vec1), .vpe_vec2(vpe_vec2), .vpe_sca(vpe_sca),
    .vpe_res(vpe_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts it, and reports a miss with both values.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load a random job into the jx/jmean/... variables.
  task automatic randomJob();
    for (int i = 0; i < DIM; i++) jx[i] = DW'($urandom);
    for (int k = 0; k < DIM/2; k++) begin
      jsin[k] = DW'($urandom);
      jcos[k] = DW'($urandom);
    end
    jmean = DW'($urandom);
    jrstd = DW'($urandom);
    jbeta = DW'($urandom);
  endtask

  // Present one job (caller is at a falling edge), act as the VPE and the
  // output consumer, and check every observable against the job's maths.
  task automatic applyStimulus(input logic [1:0] jop, input int vpeWait, input int outWait);
    logic [DIM-1:0][DW-1:0] expVec1 [2];
    logic [DIM-1:0][DW-1:0] expVec2 [2];
    logic [DIM-1:0][DW-1:0] expRes  [2];
    logic [DIM-1:0][DW-1:0] expY;
    logic                   legal;
    logic                   isRope;
    int                     reqTotal;
    int                     expLat;
    int                     reqIdx;
    int                     waited;
    int                     acksGiven;
    int                     outHeld;
    bit                     ackPrev;
    bit                     outSeen;
    bit                     done;

    isRope = (jop == 2'b01);
`ifdef SFU_RMSNORM_EN
    legal = (jop != 2'b11);
`else
    legal = (jop == 2'b00) || (jop == 2'b01);
`endif
    expVec1[0] = '0; expVec1[1] = '0;
    expVec2[0] = '0; expVec2[1] = '0;
    expY = '0;
    if (isRope) begin
      reqTotal = 2;
      expLat   = 4 + 2 * vpeWait;
      for (int i = 0; i < DIM; i++) begin
        expVec1[0][i] = jx[i];
        expVec2[0][i] = jcos[i/2];
        expVec1[1][i] = (i % 2 == 0) ? -jx[i+1] : jx[i-1];
        expVec2[1][i] = jsin[i/2];
        expRes[0][i]  = expVec1[0][i] * expVec2[0][i];
        expRes[1][i]  = expVec1[1][i] * expVec2[1][i];
        expY[i]       = expRes[0][i] + expRes[1][i];
      end
    end else begin
      reqTotal = 1;
      expLat   = ((jop == 2'b10) ? 3 : 4) + vpeWait;
      for (int i = 0; i < DIM; i++) begin
        expVec1[0][i] = (jop == 2'b10) ? jx[i] : jx[i] - jmean;
        expRes[0][i]  = expVec1[0][i] * jrstd;
        expY[i]       = expRes[0][i] + jbeta;
      end
      expRes[1] = '0;
    end

    in_valid = 1'b1;
    op       = jop;
    data_i   = jx;
    mean_i   = jmean;
    rstd_i   = jrstd;
    beta_i   = jbeta;
    sin_i    = jsin;
    cos_i    = jcos;
    checkOutput("in_ready_idle", in_ready, 1'b1);
    @(negedge clk);
    // Scramble inputs after accept; the job must not see them.
    in_valid = 1'b0;
    data_i   = {$urandom, $urandom};
    mean_i   = DW'($urandom);
    rstd_i   = DW'($urandom);
    beta_i   = DW'($urandom);
    sin_i    = $urandom;
    cos_i    = $urandom;

    if (!legal) begin
      checkOutput("err_pulse", err_o, 1'b1);
      checkOutput("err_no_vpe_req", vpe_req, 1'b0);
      checkOutput("err_no_out_valid", out_valid, 1'b0);
      checkOutput("err_in_ready", in_ready, 1'b1);
      checkOutput("err_busy", busy_o, 1'b0);
      @(negedge clk);
      checkOutput("err_single_pulse", err_o, 1'b0);
      checkOutput("err_no_out_valid2", out_valid, 1'b0);
      return;
    end

    checkOutput("legal_no_err", err_o, 1'b0);
    reqIdx = 0; waited = 0; acksGiven = 0; outHeld = 0;
    ackPrev = 0; outSeen = 0; done = 0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      checkOutput("busy", busy_o, 1'b1);
      if (vpe_req) begin
        if (ackPrev) begin
          reqIdx++;
          waited = 0;
        end
        if (reqIdx >= reqTotal) begin
          checkOutput("extra_vpe_req", 1'b1, 1'b0);
          reqIdx = reqTotal - 1;
        end
        checkOutput("vpe_vec1", vpe_vec1, expVec1[reqIdx]);
        checkOutput("vpe_mode", vpe_mode, isRope);
        if (isRope) checkOutput("vpe_vec2", vpe_vec2, expVec2[reqIdx]);
        else        checkOutput("vpe_sca", vpe_sca, jrstd);
        if (waited == vpeWait) begin
          vpe_ack = 1'b1;
          vpe_res = expRes[reqIdx];
          ackPrev = 1;
          acksGiven++;
        end else begin
          vpe_ack = 1'b0;
          vpe_res = {$urandom, $urandom};
          ackPrev = 0;
          waited++;
        end
      end else begin
        // Stray acks outside request states must be ignored.
        vpe_ack = 1'($urandom);
        vpe_res = {$urandom, $urandom};
        ackPrev = 0;
      end
      if (out_valid) begin
        if (!outSeen) checkOutput("latency", 64'(cyc), 64'(expLat));
        outSeen = 1;
        checkOutput("data_o", data_o, expY);
        checkOutput("in_ready_in_out", in_ready, 1'b0);
        if (outHeld >= outWait) begin
          out_ready = 1'b1;
          done = 1;
        end else begin
          out_ready = 1'b0;
          outHeld++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
    end
    vpe_ack   = 1'b0;
    out_ready = 1'b0;
    if (!done) checkOutput("out_timeout", 1'b0, 1'b1);
    checkOutput("vpe_ack_count", 64'(acksGiven), 64'(reqTotal));
    checkOutput("post_out_valid", out_valid, 1'b0);
    checkOutput("post_in_ready", in_ready, 1'b1);
    checkOutput("post_busy", busy_o, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    data_i    = '0;
    mean_i    = '0;
    rstd_i    = '0;
    beta_i    = '0;
    sin_i     = '0;
    cos_i     = '0;
    out_ready = 1'b0;
    vpe_ack   = 1'b0;
    vpe_res   = '0;
    #3;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_vpe_req", vpe_req, 1'b0);
    checkOutput("rst_vpe_mode", vpe_mode, 1'b0);
    checkOutput("rst_data_o", data_o, 64'd0);
    checkOutput("rst_vpe_vec1", vpe_vec1, 64'd0);
    checkOutput("rst_vpe_vec2", vpe_vec2, 64'd0);
    checkOutput("rst_vpe_sca", vpe_sca, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_in_ready", in_ready, 1'b1);

    $display("[TB] LayerNorm directed job");
    jx = {16'd40, 16'd30, 16'd20, 16'd10};
    jmean = 16'd25; jrstd = 16'd2; jbeta = 16'd5;
    jsin = '0; jcos = '0;
    applyStimulus(2'b00, 0, 0);

    $display("[TB] RoPE directed job");
    jx = {16'd4, 16'd3, 16'd2, 16'd1};
    jcos = {16'd1, 16'd1};
    jsin = {16'd2, 16'd2};
    applyStimulus(2'b01, 0, 0);

    $display("[TB] RoPE with delayed VPE acks");
    applyStimulus(2'b01, 3, 0);

    $display("[TB] LayerNorm wrap and stalled output");
    jx = {16'd7, 16'd6, 16'd5, 16'h8000};
    jmean = 16'd1; jrstd = 16'd3; jbeta = 16'hfff0;
    applyStimulus(2'b00, 1, 5);

    $display("[TB] illegal ops");
    applyStimulus(2'b11, 0, 0);
    applyStimulus(2'b10, 0, 0);

    $display("[TB] randomized jobs");
    for (int n = 0; n < 12; n++) begin
      randomJob();
      applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("[TB] reset during LN_MUL");
    randomJob();
    in_valid = 1'b1;
    op       = 2'b00;
    data_i   = jx;
    mean_i   = jmean;
    rstd_i   = jrstd;
    beta_i   = jbeta;
    @(negedge clk);
    in_valid = 1'b0;
    vpe_ack  = 1'b0;
    for (int w = 0; w < 10 && !vpe_req; w++) @(negedge clk);
    checkOutput("mid_vpe_req_before", vpe_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_vpe_req", vpe_req, 1'b0);
    checkOutput("mid_rst_busy", busy_o, 1'b0);
    checkOutput("mid_rst_vpe_vec1", vpe_vec1, 64'd0);
    checkOutput("mid_rst_vpe_sca", vpe_sca, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      checkOutput("mid_rst_no_out_valid", out_valid, 1'b0);
      checkOutput("mid_rst_no_vpe_req", vpe_req, 1'b0);
    end
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
